alu_sequencer: RTL and testbench

Microcode sequencer sitting directly upstream of the 4-bit ALU (aluROM). It accepts one macro-operation at a time over a valid/ready handshake and expands it from an internal 16-entry microcode ROM into a cycle-by-cycle stream of ALU instruction codes. While the op runs, it drives the shared 4-bit data bus with operands and captures the ALU's result or flag nibble from the bus.

---
 rtl/alu_sequencer_if.sv | 27 ++
 rtl/alu_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Macro-op handshake plus the ALU-side instruction/data bus of the sequencer.
// The master is the requester/ALU environment; the slave is the sequencer.
interface alu_sequencer_if;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] opcode;
    logic [3:0] operand_a;
    logic [3:0] operand_b;
    logic [2:0] func;
    logic [3:0] alu_instr;
    logic [3:0] bus_out;
    logic       bus_oe;
    logic [3:0] bus_in;
    logic [3:0] result;
    logic       done;
    logic       err;

    modport master (
        output op_valid, opcode, operand_a, operand_b, func, bus_in,
        input  op_ready, alu_instr, bus_out, bus_oe, result, done, err
    );

    modport slave (
        input  op_valid, opcode, operand_a, operand_b, func, bus_in,
        output op_ready, alu_instr, bus_out, bus_oe, result, done, err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Microcode sequencer: expands one macro-op into a stream of 4-bit ALU
// instructions from a 16-word ROM, driving operands and capturing results.
module alu_sequencer (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  sif
);
    typedef enum logic [1:0] {SRC_NONE, SRC_A, SRC_B, SRC_F} src_e;
    typedef enum logic {IDLE, RUN} state_e;

    typedef struct packed {
        logic [3:0] instr;
        src_e       src;
        logic       cap;
        logic       last;
    } uword_t;

    function automatic uword_t rom(input logic [3:0] addr);
        uword_t w;
        case (addr)
            4'd0:  w = '{4'h0, SRC_NONE, 1'b0, 1'b1};
            4'd1:  w = '{4'h1, SRC_A,    1'b0, 1'b0};
            4'd2:  w = '{4'h2, SRC_B,    1'b0, 1'b0};
            4'd3:  w = '{4'h5, SRC_NONE, 1'b0, 1'b0};
            4'd4:  w = '{4'h7, SRC_NONE, 1'b1, 1'b1};
            4'd5:  w = '{4'h1, SRC_A,    1'b0, 1'b0};
            4'd6:  w = '{4'h2, SRC_B,    1'b0, 1'b0};
            4'd7:  w = '{4'h6, SRC_NONE, 1'b0, 1'b0};
            4'd8:  w = '{4'h7, SRC_NONE, 1'b1, 1'b1};
            4'd9:  w = '{4'h1, SRC_A,    1'b0, 1'b0};
            4'd10: w = '{4'h2, SRC_B,    1'b0, 1'b0};
            4'd11: w = '{4'h3, SRC_F,    1'b0, 1'b0};
            4'd12: w = '{4'h4, SRC_NONE, 1'b0, 1'b0};
            4'd13: w = '{4'h7, SRC_NONE, 1'b1, 1'b1};
            4'd14: w = '{4'h8, SRC_NONE, 1'b1, 1'b1};
            default: w = '{4'hF, SRC_NONE, 1'b0, 1'b1};
        endcase
        return w;
    endfunction

    function automatic logic [3:0] start_addr(input logic [3:0] op);
        case (op)
            4'd1:    return 4'd1;
            4'd2:    return 4'd5;
            4'd3:    return 4'd9;
            4'd4:    return 4'd14;
            4'd5:    return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    state_e     state, nxt_state;
    logic [3:0] upc, nxt_upc;
    logic [3:0] a_q, b_q, nxt_a, nxt_b;
    logic [2:0] f_q, nxt_f;
    logic [3:0] alu_instr_q, bus_out_q, result_q;
    logic       bus_oe_q, done_q, err_q;
    logic       accept, legal;
    uword_t     cur_w, nxt_w;
    logic [3:0] nxt_bus;

    assign sif.op_ready  = (state == IDLE) && !rst;
    assign sif.alu_instr = alu_instr_q;
    assign sif.bus_out   = bus_out_q;
    assign sif.bus_oe    = bus_oe_q;
    assign sif.result    = result_q;
    assign sif.done      = done_q;
    assign sif.err       = err_q;

    assign accept = sif.op_valid && sif.op_ready;
    assign legal  = (sif.opcode <= 4'd5);
    assign cur_w  = rom(upc);

    always_comb begin
        nxt_state = state;
        nxt_upc   = upc;
        nxt_a     = accept ? sif.operand_a : a_q;
        nxt_b     = accept ? sif.operand_b : b_q;
        nxt_f     = accept ? sif.func      : f_q;
        if (state == IDLE) begin
            if (accept && legal) begin
                nxt_state = RUN;
                nxt_upc   = start_addr(sif.opcode);
            end
        end else if (cur_w.last) begin
            nxt_state = IDLE;
        end else begin
            nxt_upc = upc + 4'd1;
        end
    end

    // Outputs are registered from the word the next cycle will execute.
    assign nxt_w = rom(nxt_upc);

    always_comb begin
        nxt_bus = 4'h0;
        case (nxt_w.src)
            SRC_A:   nxt_bus = nxt_a;
            SRC_B:   nxt_bus = nxt_b;
            SRC_F:   nxt_bus = {1'b0, nxt_f};
            default: nxt_bus = 4'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            upc         <= 4'd0;
            a_q         <= 4'h0;
            b_q         <= 4'h0;
            f_q         <= 3'h0;
            alu_instr_q <= 4'h0;
            bus_out_q   <= 4'h0;
            bus_oe_q    <= 1'b0;
            result_q    <= 4'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state <= nxt_state;
            upc   <= nxt_upc;
            a_q   <= nxt_a;
            b_q   <= nxt_b;
            f_q   <= nxt_f;
            done_q <= ((state == RUN) && cur_w.last) || (accept && !legal);
            err_q  <= accept && !legal;
            if ((state == RUN) && cur_w.cap)
                result_q <= sif.bus_in;
            if (nxt_state == RUN) begin
                alu_instr_q <= nxt_w.instr;
                bus_oe_q    <= (nxt_w.src != SRC_NONE);
                bus_out_q   <= (nxt_w.src != SRC_NONE) ? nxt_bus : 4'h0;
            end else begin
                alu_instr_q <= 4'h0;
                bus_oe_q    <= 1'b0;
                bus_out_q   <= 4'h0;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU on the shared bus.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] alu_val = 4'h0;
    int total = 0;
    int bad = 0;
    int ndone;

    alu_sequencer_if sif ();

    alu_sequencer dut (.clk(clk), .rst(rst), .sif(sif));

    always #5 clk = ~clk;

    // ALU model: owns the bus during instr 7/8, otherwise the bus reflects the sequencer.
    assign sif.bus_in = sif.bus_oe ? sif.bus_out :
                        ((sif.alu_instr == 4'h7) || (sif.alu_instr == 4'h8)) ? alu_val : 4'h0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] ins, input logic oe, input logic [3:0] bo);
        chk({tag, " instr"}, sif.alu_instr, ins);
        chk({tag, " oe"}, 4'(sif.bus_oe), 4'(oe));
        chk({tag, " bus_out"}, sif.bus_out, bo);
        chk({tag, " done"}, 4'(sif.done), 4'd0);
    endtask

    initial begin
        sif.op_valid = 1'b0; sif.opcode = 4'h0;
        sif.operand_a = 4'h0; sif.operand_b = 4'h0; sif.func = 3'h0;
        tick(); tick();
        chk("rst ready", 4'(sif.op_ready), 4'd0);
        chk("rst instr", sif.alu_instr, 4'h0);
        chk("rst result", sif.result, 4'h0);
        chk("rst done", 4'(sif.done), 4'd0);
        rst = 1'b0;
        #1;
        chk("ready after rst", 4'(sif.op_ready), 4'd1);

        // ADD 4+1
        sif.op_valid = 1'b1; sif.opcode = 4'd1; sif.operand_a = 4'd4; sif.operand_b = 4'd1;
        alu_val = 4'd5;
        tick(); sif.op_valid = 1'b0;
        chk("add busy", 4'(sif.op_ready), 4'd0);
        step("add1", 4'h1, 1'b1, 4'd4); tick();
        step("add2", 4'h2, 1'b1, 4'd1); tick();
        step("add3", 4'h5, 1'b0, 4'd0); tick();
        step("add4", 4'h7, 1'b0, 4'd0); tick();
        chk("add done", 4'(sif.done), 4'd1);
        chk("add err", 4'(sif.err), 4'd0);
        chk("add result", sif.result, 4'd5);
        chk("add idle instr", sif.alu_instr, 4'h0);
        tick();
        chk("add done pulse", 4'(sif.done), 4'd0);

        // LOGIC func 3
        sif.op_valid = 1'b1; sif.opcode = 4'd3; sif.func = 3'd3; alu_val = 4'd3;
        tick(); sif.op_valid = 1'b0;
        step("log1", 4'h1, 1'b1, 4'd4); tick();
        step("log2", 4'h2, 1'b1, 4'd1); tick();
        step("log3", 4'h3, 1'b1, 4'd3); tick();
        step("log4", 4'h4, 1'b0, 4'd0);
        chk("log result hold", sif.result, 4'd5); tick();
        step("log5", 4'h7, 1'b0, 4'd0); tick();
        chk("log done", 4'(sif.done), 4'd1);
        chk("log result", sif.result, 4'd3);

        // FLAG then CLEAR back-to-back
        sif.opcode = 4'd4; alu_val = 4'd2; sif.op_valid = 1'b1;
        tick();
        step("flag1", 4'h8, 1'b0, 4'd0);
        sif.opcode = 4'd5;
        tick();
        chk("flag done", 4'(sif.done), 4'd1);
        chk("flag ready", 4'(sif.op_ready), 4'd1);
        chk("flag result", sif.result, 4'd2);
        tick(); sif.op_valid = 1'b0;
        step("clr1", 4'hF, 1'b0, 4'd0); tick();
        chk("clr done", 4'(sif.done), 4'd1);
        chk("clr instr", sif.alu_instr, 4'h0);
        chk("clr result", sif.result, 4'd2);

        // Illegal opcode
        sif.opcode = 4'd9; sif.op_valid = 1'b1;
        tick(); sif.op_valid = 1'b0;
        chk("ill done", 4'(sif.done), 4'd1);
        chk("ill err", 4'(sif.err), 4'd1);
        chk("ill instr", sif.alu_instr, 4'h0);
        chk("ill result", sif.result, 4'd2);
        tick();
        chk("ill err pulse", 4'(sif.err), 4'd0);
        chk("ill done pulse", 4'(sif.done), 4'd0);

        // Reset during SUB step 3
        sif.opcode = 4'd2; sif.op_valid = 1'b1; alu_val = 4'd3;
        tick(); sif.op_valid = 1'b0;
        step("sub1", 4'h1, 1'b1, 4'd4); tick();
        step("sub2", 4'h2, 1'b1, 4'd1); tick();
        step("sub3", 4'h6, 1'b0, 4'd0);
        rst = 1'b1;
        #1;
        chk("abort instr", sif.alu_instr, 4'h0);
        chk("abort oe", 4'(sif.bus_oe), 4'd0);
        chk("abort result", sif.result, 4'd0);
        chk("abort ready", 4'(sif.op_ready), 4'd0);
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sif.done) ndone++;
        end
        chk("abort no done", 4'(ndone), 4'd0);
        chk("abort ready rel", 4'(sif.op_ready), 4'd1);

        // op_valid held through a running ADD
        sif.opcode = 4'd1; sif.operand_a = 4'd2; sif.operand_b = 4'd3; alu_val = 4'd5;
        sif.op_valid = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (sif.done) ndone++;
            if (i == 5) begin
                chk("hs done", 4'(sif.done), 4'd1);
                chk("hs ready", 4'(sif.op_ready), 4'd1);
            end
            if (i == 6) begin
                chk("hs 2nd start", sif.alu_instr, 4'h1);
                sif.op_valid = 1'b0;
            end
        end
        chk("hs two dones", 4'(ndone), 4'd2);
        chk("hs result", sif.result, 4'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
